mem_arbiter: RTL and testbench

MEM_ARBITER -- requirements
Module: mem_arbiter

---
 rtl/mem_arbiter.sv | 178 +++++++++++++++++
 tb/tb_mem_arbiter.sv | 262 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_arbiter.sv
// Two-port memory arbiter: selects one requester, runs a single-cycle memory
// access (or a range-error completion) and returns a one-cycle done pulse.
module mem_arbiter #(
  parameter logic [31:0] MEM_TOP = 32'd1023,
  parameter bit          RR      = 1'b1
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [1:0]  req,
  input  logic [1:0]  rw,
  input  logic [1:0]  size0,
  input  logic [1:0]  size1,
  input  logic [31:0] addr0,
  input  logic [31:0] addr1,
  input  logic [31:0] wdata0,
  input  logic [31:0] wdata1,
  output logic [1:0]  gnt,
  output logic [1:0]  done,
  output logic        err,
  output logic [31:0] rdata,
  output logic        busy,
  output logic        m_en,
  output logic        m_rw,
  output logic [1:0]  m_size,
  output logic [31:0] m_abus,
  output logic [31:0] m_dbus_out,
  input  logic [31:0] m_dbus_in
);

  localparam int unsigned NP = 2;
  localparam int unsigned AW = 32;
  localparam int unsigned DW = 32;
  localparam int unsigned SW = 2;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    FINISH = 2'd2
  } state_t;

  state_t        state;
  state_t        state_next;
  logic          owner;
  logic          owner_next;
  logic          last_owner;
  logic          last_owner_next;
  logic [NP-1:0] gnt_next;
  logic [NP-1:0] done_next;
  logic          err_next;
  logic          busy_next;
  logic [DW-1:0] rdata_next;
  logic          m_en_next;
  logic          m_rw_next;
  logic [SW-1:0] m_size_next;
  logic [AW-1:0] m_abus_next;
  logic [DW-1:0] m_dbus_out_next;

  logic          win_c;
  logic          sel_rw_c;
  logic [SW-1:0] sel_size_c;
  logic [AW-1:0] sel_addr_c;
  logic [DW-1:0] sel_wdata_c;
  logic          in_range_c;

  function automatic logic [NP-1:0] port_onehot(input logic p);
    return p ? NP'(2'b10) : NP'(2'b01);
  endfunction

  // Arbitration: single requester wins; a tie goes to the port that did not
  // own the bus last (round-robin) or always to port 0 (fixed priority).
  always_comb begin
    win_c = 1'b0;
    case (req)
      2'b10:   win_c = 1'b1;
      2'b11:   win_c = RR ? ~last_owner : 1'b0;
      default: win_c = 1'b0;
    endcase
  end

  // Request fields of the winning port, captured only on the grant edge.
  assign sel_rw_c    = rw[win_c];
  assign sel_size_c  = win_c ? size1  : size0;
  assign sel_addr_c  = win_c ? addr1  : addr0;
  assign sel_wdata_c = win_c ? wdata1 : wdata0;
  assign in_range_c  = (sel_addr_c <= MEM_TOP);

  // Next-state and next-output logic; memory bus fields hold unless a new
  // in-range access is launched.
  always_comb begin
    state_next      = state;
    owner_next      = owner;
    last_owner_next = last_owner;
    gnt_next        = gnt;
    done_next       = '0;
    err_next        = 1'b0;
    rdata_next      = rdata;
    m_en_next       = 1'b0;
    m_rw_next       = m_rw;
    m_size_next     = m_size;
    m_abus_next     = m_abus;
    m_dbus_out_next = m_dbus_out;

    case (state)
      IDLE: begin
        gnt_next = '0;
        if (req != '0) begin
          owner_next      = win_c;
          last_owner_next = win_c;
          gnt_next        = port_onehot(win_c);
          if (in_range_c) begin
            state_next      = ACCESS;
            m_en_next       = 1'b1;
            m_rw_next       = sel_rw_c;
            m_size_next     = sel_size_c;
            m_abus_next     = sel_addr_c;
            m_dbus_out_next = sel_wdata_c;
          end else begin
            state_next = FINISH;
            done_next  = port_onehot(win_c);
            err_next   = 1'b1;
            rdata_next = '0;
          end
        end
      end
      ACCESS: begin
        state_next = FINISH;
        done_next  = port_onehot(owner);
        if (m_rw) begin
          rdata_next = m_dbus_in;
        end
      end
      FINISH: begin
        state_next = IDLE;
        gnt_next   = '0;
      end
      default: begin
        state_next = IDLE;
        gnt_next   = '0;
      end
    endcase

    busy_next = (state_next != IDLE);
  end

  // State and registered outputs; reset aborts any transaction immediately.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      owner      <= 1'b0;
      last_owner <= 1'b1;
      gnt        <= '0;
      done       <= '0;
      err        <= 1'b0;
      busy       <= 1'b0;
      rdata      <= '0;
      m_en       <= 1'b0;
      m_rw       <= 1'b1;
      m_size     <= '0;
      m_abus     <= '0;
      m_dbus_out <= '0;
    end else begin
      state      <= state_next;
      owner      <= owner_next;
      last_owner <= last_owner_next;
      gnt        <= gnt_next;
      done       <= done_next;
      err        <= err_next;
      busy       <= busy_next;
      rdata      <= rdata_next;
      m_en       <= m_en_next;
      m_rw       <= m_rw_next;
      m_size     <= m_size_next;
      m_abus     <= m_abus_next;
      m_dbus_out <= m_dbus_out_next;
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: vector table of single-port transactions
// plus hand-written hold, tie, fixed-priority and reset sequences.
module tb_mem_arbiter;

  localparam int unsigned MEM_BYTES = 1024;
  localparam int unsigned MAW       = 10;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic [1:0]  req = '0;
  logic [1:0]  rw = '0;
  logic [1:0]  size0 = '0;
  logic [1:0]  size1 = '0;
  logic [31:0] addr0 = '0;
  logic [31:0] addr1 = '0;
  logic [31:0] wdata0 = '0;
  logic [31:0] wdata1 = '0;
  logic [1:0]  gnt;
  logic [1:0]  done;
  logic        err;
  logic [31:0] rdata;
  logic        busy;
  logic        m_en;
  logic        m_rw;
  logic [1:0]  m_size;
  logic [31:0] m_abus;
  logic [31:0] m_dbus_out;
  logic [31:0] m_dbus_in;

  logic [1:0]  req_fp = '0;
  logic [1:0]  gnt_fp;
  logic [1:0]  done_fp;
  logic        err_fp;
  logic [31:0] rdata_fp;
  logic        busy_fp;
  logic        m_en_fp;
  logic        m_rw_fp;
  logic [1:0]  m_size_fp;
  logic [31:0] m_abus_fp;
  logic [31:0] m_dbus_out_fp;
  logic [31:0] m_dbus_in_fp;

  int errors = 0;
  int checks = 0;

  logic [7:0]  mem [MEM_BYTES];
  logic        mem_init = 1'b0;
  logic [31:0] rd_val;

  always #5 clock = ~clock;

  mem_arbiter #(.MEM_TOP(32'd1023), .RR(1'b1)) dut (
    .clock(clock), .reset(reset), .req(req), .rw(rw),
    .size0(size0), .size1(size1), .addr0(addr0), .addr1(addr1),
    .wdata0(wdata0), .wdata1(wdata1), .gnt(gnt), .done(done), .err(err),
    .rdata(rdata), .busy(busy), .m_en(m_en), .m_rw(m_rw), .m_size(m_size),
    .m_abus(m_abus), .m_dbus_out(m_dbus_out), .m_dbus_in(m_dbus_in)
  );

  mem_arbiter #(.MEM_TOP(32'd1023), .RR(1'b0)) dut_fp (
    .clock(clock), .reset(reset), .req(req_fp), .rw(rw),
    .size0(size0), .size1(size1), .addr0(addr0), .addr1(addr1),
    .wdata0(wdata0), .wdata1(wdata1), .gnt(gnt_fp), .done(done_fp), .err(err_fp),
    .rdata(rdata_fp), .busy(busy_fp), .m_en(m_en_fp), .m_rw(m_rw_fp), .m_size(m_size_fp),
    .m_abus(m_abus_fp), .m_dbus_out(m_dbus_out_fp), .m_dbus_in(m_dbus_in_fp)
  );

  assign m_dbus_in_fp = 32'h5A5A_5A5A;

  // Byte memory, big-endian, right-aligned data; preload while mem_init is high.
  always @(posedge clock) begin
    if (mem_init) begin
      for (int i = 0; i < int'(MEM_BYTES); i++) mem[i] <= 8'h00;
      mem[0] <= 8'h08; mem[1] <= 8'h1E; mem[2] <= 8'h00; mem[3] <= 8'h05;
      mem[4] <= 8'h44; mem[5] <= 8'h55; mem[6] <= 8'h66; mem[7] <= 8'h77;
      mem[8] <= 8'h3C;
      mem[1020] <= 8'h11; mem[1021] <= 8'h22; mem[1022] <= 8'h33; mem[1023] <= 8'h44;
    end else if (m_en && !m_rw) begin
      for (int k = 0; k < 4; k++) begin
        if (k <= int'(m_size))
          mem[MAW'(m_abus + 32'(k))] <= 8'(m_dbus_out >> (8 * (int'(m_size) - k)));
      end
    end
  end

  // Combinational read port; returns a junk pattern when not read-enabled.
  always_comb begin
    rd_val = '0;
    for (int k = 0; k < 4; k++) begin
      if (k <= int'(m_size)) rd_val = {rd_val[23:0], mem[MAW'(m_abus + 32'(k))]};
    end
    m_dbus_in = (m_en && m_rw) ? rd_val : 32'hBAD0_BAD0;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  typedef struct {
    logic        port;
    logic        rd;
    logic [1:0]  size;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] exp_rdata;
    logic        exp_err;
  } vec_t;

  vec_t vecs [11];

  // One single-port transaction; entered and left at posedge+1 in IDLE.
  task automatic run_vec(input vec_t v);
    int lat = -1;
    int en_cnt = 0;
    logic [1:0] oh;
    oh = v.port ? 2'b10 : 2'b01;
    rw[v.port] = v.rd;
    if (v.port) begin
      size1 = v.size; addr1 = v.addr; wdata1 = v.wdata;
    end else begin
      size0 = v.size; addr0 = v.addr; wdata0 = v.wdata;
    end
    req[v.port] = 1'b1;
    @(posedge clock); #1;
    for (int c = 1; c <= 8; c++) begin
      if (m_en) begin
        en_cnt++;
        chk("m_rw", 32'(m_rw), 32'(v.rd));
        chk("m_size", 32'(m_size), 32'(v.size));
        chk("m_abus", m_abus, v.addr);
        if (!v.rd) chk("m_dbus_out", m_dbus_out, v.wdata);
      end
      if (done != 2'b00) begin
        lat = c;
        break;
      end
      @(posedge clock); #1;
    end
    chk("latency", 32'(lat), v.exp_err ? 32'd1 : 32'd2);
    chk("en_cycles", 32'(en_cnt), v.exp_err ? 32'd0 : 32'd1);
    chk("done", 32'(done), 32'(oh));
    chk("gnt", 32'(gnt), 32'(oh));
    chk("busy_fin", 32'(busy), 32'd1);
    chk("err", 32'(err), 32'(v.exp_err));
    chk("rdata", rdata, v.exp_rdata);
    req[v.port] = 1'b0;
    @(posedge clock); #1;
    chk("idle_busy", 32'(busy), 32'd0);
    chk("idle_gnt", 32'(gnt), 32'd0);
    chk("idle_done", 32'(done), 32'd0);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0]  = '{1'b0, 1'b1, 2'd3, 32'd0,          32'h0,         32'h081E_0005, 1'b0};
    vecs[1]  = '{1'b1, 1'b0, 2'd0, 32'd16,         32'h0000_00A5, 32'h081E_0005, 1'b0};
    vecs[2]  = '{1'b1, 1'b1, 2'd0, 32'd16,         32'h0,         32'h0000_00A5, 1'b0};
    vecs[3]  = '{1'b0, 1'b1, 2'd3, 32'd1024,       32'h0,         32'h0000_0000, 1'b1};
    vecs[4]  = '{1'b0, 1'b1, 2'd3, 32'd1020,       32'h0,         32'h1122_3344, 1'b0};
    vecs[5]  = '{1'b1, 1'b0, 2'd1, 32'd32,         32'h1234_BEEF, 32'h1122_3344, 1'b0};
    vecs[6]  = '{1'b0, 1'b1, 2'd2, 32'd32,         32'h0,         32'h00BE_EF00, 1'b0};
    vecs[7]  = '{1'b0, 1'b0, 2'd3, 32'd40,         32'hCAFE_F00D, 32'h00BE_EF00, 1'b0};
    vecs[8]  = '{1'b1, 1'b1, 2'd3, 32'd40,         32'h0,         32'hCAFE_F00D, 1'b0};
    vecs[9]  = '{1'b1, 1'b1, 2'd3, 32'hFFFF_FFFF,  32'h0,         32'h0000_0000, 1'b1};
    vecs[10] = '{1'b0, 1'b1, 2'd1, 32'd41,         32'h0,         32'h0000_FEF0, 1'b0};

    // Reset values
    #1 reset = 1'b1;
    mem_init = 1'b1;
    #1;
    chk("rst_gnt", 32'(gnt), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_err", 32'(err), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_rdata", rdata, 32'd0);
    chk("rst_m_en", 32'(m_en), 32'd0);
    chk("rst_m_rw", 32'(m_rw), 32'd1);
    chk("rst_m_size", 32'(m_size), 32'd0);
    chk("rst_m_abus", m_abus, 32'd0);
    chk("rst_m_dbus_out", m_dbus_out, 32'd0);
    @(posedge clock); @(posedge clock); #1;
    reset = 1'b0;
    mem_init = 1'b0;

    // Vector table
    for (int i = 0; i < 11; i++) run_vec(vecs[i]);

    // Hold: owner's address changes during ACCESS have no effect
    rw[0] = 1'b1; size0 = 2'd3; addr0 = 32'd4; req[0] = 1'b1;
    @(posedge clock); #1;
    chk("hold_m_en", 32'(m_en), 32'd1);
    chk("hold_abus_acc", m_abus, 32'd4);
    addr0 = 32'd12;
    #1 chk("hold_abus_acc2", m_abus, 32'd4);
    @(posedge clock); #1;
    chk("hold_done", 32'(done), 32'd1);
    chk("hold_abus_fin", m_abus, 32'd4);
    chk("hold_rdata", rdata, 32'h4455_6677);
    req[0] = 1'b0;
    @(posedge clock); #1;
    chk("hold_abus_idle", m_abus, 32'd4);

    // Tie: round-robin alternates from port 0, fixed priority always port 0
    reset = 1'b1;
    @(posedge clock); #1;
    reset = 1'b0;
    rw = 2'b11; size0 = 2'd3; addr0 = 32'd0; size1 = 2'd0; addr1 = 32'd16;
    req = 2'b11; req_fp = 2'b11;
    begin
      int got = 0;
      for (int c = 0; c < 40 && got < 4; c++) begin
        @(posedge clock); #1;
        if (done != 2'b00) begin
          chk("tie_rr_order", 32'(done), (got % 2 == 0) ? 32'd1 : 32'd2);
          chk("tie_fp_order", 32'(done_fp), 32'd1);
          got++;
        end
      end
      chk("tie_count", 32'(got), 32'd4);
    end
    req = 2'b00; req_fp = 2'b00;
    chk("tie_fp_rdata", rdata_fp, 32'h5A5A_5A5A);
    @(posedge clock); #1;
    chk("tie_idle", 32'(busy), 32'd0);

    // Reset in the ACCESS cycle of a port 1 write to byte 8
    rw[1] = 1'b0; size1 = 2'd0; addr1 = 32'd8; wdata1 = 32'h0000_0099; req = 2'b10;
    @(posedge clock); #1;
    chk("rst_acc_m_en", 32'(m_en), 32'd1);
    #2 reset = 1'b1;
    #1;
    chk("rst_async_m_en", 32'(m_en), 32'd0);
    chk("rst_async_busy", 32'(busy), 32'd0);
    chk("rst_async_gnt", 32'(gnt), 32'd0);
    chk("rst_async_abus", m_abus, 32'd0);
    @(posedge clock); #1;
    chk("rst_no_done", 32'(done), 32'd0);
    chk("rst_mem8", 32'(mem[8]), 32'h0000_003C);
    reset = 1'b0;
    @(posedge clock); #1;
    chk("rst_new_m_en", 32'(m_en), 32'd1);
    chk("rst_new_abus", m_abus, 32'd8);
    @(posedge clock); #1;
    chk("rst_new_done", 32'(done), 32'd2);
    req = 2'b00;
    @(posedge clock); #1;
    chk("rst_new_mem8", 32'(mem[8]), 32'h0000_0099);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
